pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It generates the per-stage stall vector from two sources:
- load-use hazards detected at ID, where forwarding from EX cannot help because the load data is not ready yet;
- multi-cycle EX operations (div, madd/msub), which it sequences with a counter FSM and a request/done handshake.

It also handles pipeline flush. It sits beside id/ex and drives the hold inputs of pc_reg and every pipeline register.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall vector for the 5-stage core from load-use hazards and multi-cycle EX ops.
// Latency: stall_o is combinational; an L-cycle op gives L stall cycles then a 1-cycle mc_done_o pulse.
// Backpressure: stall_o holds pc and pipeline registers; EX keeps ex_mc_req_i until mc_done_o. PIPE_CTRL_PERF_EN adds stall counters.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_wreg_i,
  input  logic [4:0]       ex_wd_i,
  input  logic             ex_mc_req_i,
  input  logic [CNT_W-1:0] ex_mc_len_i,
  output logic             mc_done_o,
  output logic [5:0]       stall_o,
  output logic             busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_mc_cycles_o,
  output logic [PERF_W-1:0] perf_lu_cycles_o
`endif
);

  localparam logic [5:0] STALL_MC = 6'b001111;
  localparam logic [5:0] STALL_LU = 6'b000111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_eff;
  logic             lu_hazard;
  logic [5:0]       stall_c;
  logic             done_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = '0;
    done_c  = 1'b0;
    len_eff = (ex_mc_len_i == '0) ? CNT_W'(1) : ex_mc_len_i;
    // r0 is hardwired zero, so a load "to" it never creates a real dependency
    lu_hazard = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
                 (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_mc_req_i) begin
            stall_c = STALL_MC;
            if (len_eff == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              cnt_d   = len_eff - CNT_W'(1);
              state_d = BUSY;
            end
          end else if (lu_hazard) begin
            stall_c = STALL_LU;
          end
        end
        BUSY: begin
          stall_c = STALL_MC;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // EX releases here so the result advances; a new request is only seen from IDLE
          done_c  = 1'b1;
          state_d = IDLE;
          if (lu_hazard) stall_c = STALL_LU;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall_o   = rst ? 6'b000000 : stall_c;
  assign mc_done_o = rst ? 1'b0 : done_c;
  assign busy_o    = rst ? 1'b0 : (state_q != IDLE);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mc_cycles_o <= '0;
      perf_lu_cycles_o <= '0;
    end else begin
      if (stall_o == STALL_MC) perf_mc_cycles_o <= perf_mc_cycles_o + PERF_W'(1);
      if (stall_o == STALL_LU) perf_lu_cycles_o <= perf_lu_cycles_o + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; a per-cycle reference model queues expected outputs.
// A negedge monitor pops and compares; directed cases from the plan, then randomized traffic.
module tb_pipe_ctrl;
  localparam int CNT_W  = 6;
  localparam int PERF_W = 4;
  localparam logic [5:0] S_MC = 6'b001111;
  localparam logic [5:0] S_LU = 6'b000111;

  logic             clk = 1'b0;
  logic             rst, flush_i;
  logic             id_reg1_read_i, id_reg2_read_i;
  logic [4:0]       id_reg1_addr_i, id_reg2_addr_i;
  logic             ex_is_load_i, ex_wreg_i;
  logic [4:0]       ex_wd_i;
  logic             ex_mc_req_i;
  logic [CNT_W-1:0] ex_mc_len_i;
  logic             mc_done_o, busy_o;
  logic [5:0]       stall_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_mc_cycles_o, perf_lu_cycles_o;
`endif

  pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_mc_req_i(ex_mc_req_i), .ex_mc_len_i(ex_mc_len_i),
    .mc_done_o(mc_done_o), .stall_o(stall_o), .busy_o(busy_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_mc_cycles_o(perf_mc_cycles_o), .perf_lu_cycles_o(perf_lu_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]        stall;
    logic              done;
    logic              busy;
    logic              rst;
    logic [PERF_W-1:0] pmc;
    logic [PERF_W-1:0] plu;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // model: stall cycles still owed by an accepted op, and whether a done cycle follows
  int m_rem  = 0;
  bit m_done = 0;
  int m_pmc  = 0;
  int m_plu  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    int   len;
    bit   lu;
    lu = ex_is_load_i && ex_wreg_i && (ex_wd_i != 0) &&
         ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
          (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
    e.rst   = rst;
    e.pmc   = PERF_W'(m_pmc);
    e.plu   = PERF_W'(m_plu);
    e.busy  = !rst && (m_rem > 0 || m_done);
    e.stall = 6'b0;
    e.done  = 1'b0;
    if (rst) begin
      m_rem = 0; m_done = 0; m_pmc = 0; m_plu = 0;
    end else if (flush_i) begin
      m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      e.stall = S_MC;
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (m_done) begin
      e.done  = 1'b1;
      e.stall = lu ? S_LU : 6'b0;
      m_done  = 0;
    end else if (ex_mc_req_i) begin
      len     = (ex_mc_len_i == 0) ? 1 : int'(ex_mc_len_i);
      e.stall = S_MC;
      m_rem   = len - 1;
      if (m_rem == 0) m_done = 1;
    end else if (lu) begin
      e.stall = S_LU;
    end
    if (!rst) begin
      if (e.stall == S_MC) m_pmc = (m_pmc + 1) % (1 << PERF_W);
      if (e.stall == S_LU) m_plu = (m_plu + 1) % (1 << PERF_W);
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall", int'(stall_o), int'(e.stall));
      chk("mc_done", int'(mc_done_o), int'(e.done));
      chk("busy", int'(busy_o), int'(e.busy));
`ifdef PIPE_CTRL_PERF_EN
      if (!e.rst) begin
        chk("perf_mc", int'(perf_mc_cycles_o), int'(e.pmc));
        chk("perf_lu", int'(perf_lu_cycles_o), int'(e.plu));
      end
`endif
    end
  end

  task automatic quiet();
    flush_i = 0; id_reg1_read_i = 0; id_reg1_addr_i = 0; id_reg2_read_i = 0;
    id_reg2_addr_i = 0; ex_is_load_i = 0; ex_wreg_i = 0; ex_wd_i = 0;
    ex_mc_req_i = 0; ex_mc_len_i = 0;
  endtask

  task automatic set_lu(input logic [4:0] wd);
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = wd;
    id_reg2_read_i = 1; id_reg2_addr_i = 5;
  endtask

  // request held through the stall cycles and the done cycle, dropped afterwards
  task automatic mc_op(input int len);
    int eff;
    eff = (len == 0) ? 1 : len;
    ex_mc_req_i = 1; ex_mc_len_i = CNT_W'(len);
    repeat (eff + 1) step();
    ex_mc_req_i = 0;
  endtask

  initial begin
    rst = 1;
    quiet();
    @(posedge clk);
    #1;
    step(); step();
    rst = 0;
    step();

    set_lu(5); step();
    set_lu(0); step();
    quiet();

    mc_op(3); step(); step();
    mc_op(1); step();
    mc_op(0); step();
    mc_op(63); step();

    set_lu(5); mc_op(4); step(); quiet(); step();

    ex_mc_req_i = 1; ex_mc_len_i = 5; step();
    ex_mc_req_i = 0; step();
    flush_i = 1; step();
    flush_i = 0; repeat (6) step();

    ex_mc_req_i = 1; ex_mc_len_i = 5; step();
    ex_mc_req_i = 0; step();
    rst = 1; step();
    rst = 0; repeat (6) step();

    flush_i = 1; ex_mc_req_i = 1; ex_mc_len_i = 3; step();
    quiet(); step();

    mc_op(3);
    set_lu(5); step(); step();
    quiet(); step();
    set_lu(7); id_reg1_read_i = 1; id_reg1_addr_i = 7; id_reg2_addr_i = 9;
    repeat (20) step();
    quiet(); step();

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      id_reg1_read_i = $urandom_range(0, 1);
      id_reg1_addr_i = 5'($urandom_range(0, 3));
      id_reg2_read_i = $urandom_range(0, 1);
      id_reg2_addr_i = 5'($urandom_range(0, 3));
      ex_is_load_i   = $urandom_range(0, 1);
      ex_wreg_i      = $urandom_range(0, 1);
      ex_wd_i        = 5'($urandom_range(0, 3));
      ex_mc_req_i    = ($urandom_range(0, 3) == 0);
      ex_mc_len_i    = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 63))
                                                   : CNT_W'($urandom_range(0, 5));
      step();
    end
    rst = 0;
    quiet();
    repeat (2) @(posedge clk);
    chk("drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
